// File: rtl/nvram_upload.sv
// rtl/nvram_upload.sv - NVRAM with HPS upload/restore path and autosave request
module nvram_upload #(
    parameter int         ADDR_W          = 10,
    parameter logic [7:0] IOCTL_IDX       = 8'd4,
    parameter int         AUTOSAVE_FRAMES = 120
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_upload_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_d,
    output logic [7:0]        cpu_q,
    output logic              cpu_hold,
    input  logic              vblank
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(AUTOSAVE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(AUTOSAVE_FRAMES);

    typedef enum logic [1:0] {IDLE, UPLOAD, RESTORE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              blocked;
    logic [7:0]        mem [DEPTH] = '{default: 8'h00};
    logic [7:0]        rd_data;
    logic              rd_vld;
    logic              rd_oor;
    logic              dirty;
    logic [CNT_W-1:0]  quiet_cnt;
    logic              vb_q;

    logic              sel;
    logic              hps_in_range;
    logic              cpu_wr_en;
    logic              hps_wr_en;
    logic              hps_rd;
    logic              vb_rise;
    logic              clear_dirty;

    assign sel          = (ioctl_index == IOCTL_IDX);
    assign hps_in_range = ~|ioctl_addr[24:ADDR_W];
    assign cpu_wr_en    = cpu_we && (state != RESTORE);
    assign hps_wr_en    = (state == RESTORE) && ioctl_wr && hps_in_range;
    assign hps_rd       = (state == UPLOAD) && ioctl_rd;
    assign vb_rise      = vblank && !vb_q;
    assign cpu_hold     = (state == RESTORE);
    assign clear_dirty  = ((state == IDLE) && (state_nxt == UPLOAD)) ||
                          ((state == RESTORE) && (state_nxt == IDLE));

    // CPU and HPS writes never collide: CPU writes are gated off during RESTORE.
    always_ff @(posedge clk_sys) begin
        if (cpu_wr_en)
            mem[cpu_addr] <= cpu_d;
        if (hps_wr_en)
            mem[ioctl_addr[ADDR_W-1:0]] <= ioctl_dout;
        if (hps_rd && hps_in_range)
            rd_data <= mem[ioctl_addr[ADDR_W-1:0]];
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            cpu_q <= 8'h00;
        else
            cpu_q <= mem[cpu_addr];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_vld    <= 1'b0;
            rd_oor    <= 1'b0;
            ioctl_din <= 8'hFF;
        end else begin
            rd_vld <= hps_rd;
            rd_oor <= !hps_in_range;
            if (rd_vld)
                ioctl_din <= rd_oor ? 8'hFF : rd_data;
        end
    end

    // After a reset, a session already in flight is ignored until both strobes drop.
    always_ff @(posedge clk_sys) begin
        if (reset)
            blocked <= 1'b1;
        else if (!ioctl_upload && !ioctl_download)
            blocked <= 1'b0;
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!blocked && sel && ioctl_upload)
                    state_nxt = UPLOAD;
                else if (!blocked && sel && ioctl_download)
                    state_nxt = RESTORE;
            end
            UPLOAD:  if (!ioctl_upload)   state_nxt = IDLE;
            RESTORE: if (!ioctl_download) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A CPU write always re-arms the quiet timer, even on the terminal vblank edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dirty            <= 1'b0;
            quiet_cnt        <= '0;
            ioctl_upload_req <= 1'b0;
            vb_q             <= 1'b0;
        end else begin
            vb_q             <= vblank;
            ioctl_upload_req <= 1'b0;
            if (cpu_wr_en) begin
                dirty     <= 1'b1;
                quiet_cnt <= '0;
            end else if (clear_dirty) begin
                dirty     <= 1'b0;
                quiet_cnt <= '0;
            end else if ((state == IDLE) && dirty && vb_rise && (quiet_cnt != CNT_MAX)) begin
                quiet_cnt        <= quiet_cnt + 1'b1;
                ioctl_upload_req <= (quiet_cnt == CNT_MAX - 1'b1);
            end
        end
    end

endmodule
